// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a combinational instruction ROM.
// Fetch (I) and load (D) share the ROM; every accepted read returns exactly two cycles later.
module rom_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 i_ack,
  output logic                 i_rdy,
  output logic [DATA_BITS-1:0] i_data,
  input  logic                 d_req,
  input  logic [ADDR_BITS-1:0] d_addr,
  output logic                 d_ack,
  output logic                 d_rdy,
  output logic [DATA_BITS-1:0] d_data,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 rom_sel,
  input  logic [DATA_BITS-1:0] rom_dout
);

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  logic [ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                 rom_sel_q, rom_sel_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 i_rdy_q, i_rdy_d;
  logic                 d_rdy_q, d_rdy_d;
  logic [DATA_BITS-1:0] i_data_q, i_data_d;
  logic [DATA_BITS-1:0] d_data_q, d_data_d;
  port_e                tag_q, tag_d;
  port_e                last_winner_q, last_winner_d;

  logic grant_i, grant_d, accept;

  // On conflict the port that did not win the previous acceptance goes first.
  always_comb begin
    grant_i = i_req && (!d_req || last_winner_q == PORT_D);
    grant_d = d_req && !grant_i;
    accept  = grant_i || grant_d;
  end

  always_comb begin
    rom_sel_d     = accept;
    rom_addr_d    = rom_addr_q;
    i_ack_d       = grant_i;
    d_ack_d       = grant_d;
    tag_d         = tag_q;
    last_winner_d = last_winner_q;
    if (grant_i) begin
      rom_addr_d    = i_addr;
      tag_d         = PORT_I;
      last_winner_d = PORT_I;
    end else if (grant_d) begin
      rom_addr_d    = d_addr;
      tag_d         = PORT_D;
      last_winner_d = PORT_D;
    end
  end

  // The ROM answers the previous acceptance now; steer it to the tagged port only.
  always_comb begin
    i_rdy_d  = rom_sel_q && (tag_q == PORT_I);
    d_rdy_d  = rom_sel_q && (tag_q == PORT_D);
    i_data_d = i_rdy_d ? rom_dout : i_data_q;
    d_data_d = d_rdy_d ? rom_dout : d_data_q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q    <= '0;
      rom_sel_q     <= 1'b0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      i_rdy_q       <= 1'b0;
      d_rdy_q       <= 1'b0;
      i_data_q      <= '0;
      d_data_q      <= '0;
      tag_q         <= PORT_I;
      last_winner_q <= PORT_D;
    end else begin
      rom_addr_q    <= rom_addr_d;
      rom_sel_q     <= rom_sel_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      i_rdy_q       <= i_rdy_d;
      d_rdy_q       <= d_rdy_d;
      i_data_q      <= i_data_d;
      d_data_q      <= d_data_d;
      tag_q         <= tag_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_sel  = rom_sel_q;
  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rdy    = i_rdy_q;
  assign d_rdy    = d_rdy_q;
  assign i_data   = i_data_q;
  assign d_data   = d_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_rom_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_ack, i_rdy, d_ack, d_rdy;
  logic [DW-1:0] i_data, d_data;
  logic [AW-1:0] rom_addr;
  logic          rom_sel;
  logic [DW-1:0] rom_dout;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567 ^ (a >> 7);
  endfunction

  // Combinational ROM: returns 0 whenever it is not selected.
  assign rom_dout = rom_sel ? mem(rom_addr) : '0;

  rom_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdy(i_rdy), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdy(d_rdy), .d_data(d_data),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_dout(rom_dout)
  );

  typedef struct {
    bit            to_d;
    logic [DW-1:0] data;
  } read_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending returns, expected outputs, arbitration history.
  read_t         pend[$];
  logic [AW-1:0] i_list[$];
  logic [AW-1:0] d_list[$];
  bit            last_was_i;
  logic          e_i_ack, e_d_ack, e_i_rdy, e_d_rdy, e_sel;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_i_data, e_d_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".i_ack"},    32'(i_ack),   32'(e_i_ack));
    check({tag, ".d_ack"},    32'(d_ack),   32'(e_d_ack));
    check({tag, ".rom_sel"},  32'(rom_sel), 32'(e_sel));
    check({tag, ".rom_addr"}, rom_addr,     e_addr);
    check({tag, ".i_rdy"},    32'(i_rdy),   32'(e_i_rdy));
    check({tag, ".d_rdy"},    32'(d_rdy),   32'(e_d_rdy));
    check({tag, ".i_data"},   i_data,       e_i_data);
    check({tag, ".d_data"},   d_data,       e_d_data);
  endtask

  task automatic model_reset();
    pend.delete();
    last_was_i = 1'b0;
    {e_i_ack, e_d_ack, e_i_rdy, e_d_rdy, e_sel} = '0;
    e_addr   = '0;
    e_i_data = '0;
    e_d_data = '0;
  endtask

  task automatic drive();
    i_req = (i_list.size() > 0);
    if (i_req) i_addr = i_list[0];
    d_req = (d_list.size() > 0);
    if (d_req) d_addr = d_list[0];
  endtask

  // One clock: update the model from the inputs sampled at the edge, check, then react to acks.
  task automatic step(input string tag);
    bit win_i, win_d;
    read_t r;
    @(posedge clk);
    e_i_rdy = 1'b0;
    e_d_rdy = 1'b0;
    if (pend.size() > 0) begin
      r = pend.pop_front();
      if (r.to_d) begin e_d_rdy = 1'b1; e_d_data = r.data; end
      else        begin e_i_rdy = 1'b1; e_i_data = r.data; end
    end
    win_i = 1'b0;
    win_d = 1'b0;
    if (i_req && d_req) begin
      if (last_was_i) win_d = 1'b1;
      else            win_i = 1'b1;
    end else begin
      win_i = i_req;
      win_d = d_req;
    end
    e_i_ack = win_i;
    e_d_ack = win_d;
    e_sel   = win_i || win_d;
    if (win_i) begin
      e_addr = i_addr; last_was_i = 1'b1;
      pend.push_back('{to_d: 1'b0, data: mem(i_addr)});
    end else if (win_d) begin
      e_addr = d_addr; last_was_i = 1'b0;
      pend.push_back('{to_d: 1'b1, data: mem(d_addr)});
    end
    #1;
    check_all(tag);
    if (win_i) void'(i_list.pop_front());
    if (win_d) void'(d_list.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int steps = 0;
    drive();
    while ((i_list.size() > 0 || d_list.size() > 0 || pend.size() > 0) && steps < budget) begin
      step(tag);
      steps++;
    end
    check({tag, ".budget"}, 32'(steps < budget), 32'd1);
  endtask

  task automatic hard_reset();
    i_list.delete();
    d_list.delete();
    drive();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    i_req  = 1'b0; d_req  = 1'b0;
    i_addr = '0;   d_addr = '0;
    model_reset();
    hard_reset();

    // Single I read.
    i_list.push_back(32'h10);
    drain("single_i", 10);

    // First conflict after reset: I must win.
    hard_reset();
    i_list.push_back(32'h4);
    d_list.push_back(32'h8);
    drain("first_conflict", 10);

    // Sustained contention: alternating grants, ROM busy every cycle.
    for (int k = 0; k < 4; k++) begin
      i_list.push_back(32'h100 + 32'(k));
      d_list.push_back(32'h200 + 32'(k));
    end
    drain("contention", 20);

    // Back-to-back stream on one port.
    for (int k = 0; k < 4; k++) i_list.push_back(32'(k));
    drain("stream_i", 12);

    // Reset asserted asynchronously during the ack cycle of a D read.
    d_list.push_back(32'h20);
    drive();
    step("mid_flight");
    #1;
    hard_reset();
    repeat (3) step("post_reset_idle");
    i_list.push_back(32'h44);
    d_list.push_back(32'h88);
    drain("post_reset_conflict", 10);

    // Idle hold after a D read.
    d_list.push_back(32'h30);
    drain("d_read", 10);
    repeat (5) step("idle_hold");

    // Randomized traffic obeying the requester protocol.
    for (int n = 0; n < 400; n++) begin
      if (i_list.size() == 0 && $urandom_range(0, 2) != 0) i_list.push_back($urandom());
      if (d_list.size() == 0 && $urandom_range(0, 2) != 0) d_list.push_back($urandom());
      drive();
      step("random");
    end
    drain("random_drain", 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares a single combinational read-only memory between two requesters: instruction fetch (port I) and data load (port D).
- Each accepted request is driven onto the ROM address/select lines for one cycle; the ROM output is registered and returned to the winning port.
- Round-robin arbitration on conflict; sustained throughput of one read per cycle; fixed 2-cycle latency from acceptance to data.
- Sits between the fetch/memory stages and the instruction ROM.

Parameters:
- ADDR_BITS, 32, ROM address width
- DATA_BITS, 32, ROM data width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- i_req  input  1  port I read request, level
- i_addr  input  ADDR_BITS  port I read address
- i_ack  output  1  port I request accepted (registered pulse)
- i_rdy  output  1  port I data valid (registered pulse)
- i_data  output  DATA_BITS  port I read data
- d_req  input  1  port D read request, level
- d_addr  input  ADDR_BITS  port D read address
- d_ack  output  1  port D request accepted (registered pulse)
- d_rdy  output  1  port D data valid (registered pulse)
- d_data  output  DATA_BITS  port D read data
- rom_addr  output  ADDR_BITS  to ROM addr (registered)
- rom_sel  output  1  to ROM sel (registered)
- rom_dout  input  DATA_BITS  from ROM dout (combinational)

Behaviour:
- Reset (async, rst=1): i_ack, d_ack, i_rdy, d_rdy, rom_sel = 0; rom_addr, i_data, d_data = 0; in-flight tag cleared; last_winner = D, so I wins the first conflict.
- Acceptance at rising edge E:
  - Arbitrates among asserted reqs.
  - Winner's addr → rom_addr; rom_sel ← 1; winner's ack ← 1 for cycle after E; in-flight tag ← winner; last_winner ← winner.
  - No req at E: rom_sel ← 0, acks ← 0, rom_addr holds.
- Arbitration:
  - Single requester wins.
  - Both requesting: the port that is not last_winner wins.
  - last_winner updates only on acceptance.
- Data capture at edge E+1 (if rom_sel=1 during cycle E+1):
  - rom_dout → tagged port's data register.
  - That port's rdy = 1 for cycle after E+1.
  - Other port's data register holds; rdy pulses are exactly one cycle.
- Latency: req sampled at edge E → ack during cycle E+1 → rdy/data during cycle E+2.
- Pipelining: capture of request n and acceptance of request n+1 occur at the same edge. Back-to-back reads with no bubble.
- Requester protocol:
  - Hold req and addr stable until ack is seen.
  - In the ack cycle, drop req or present the next addr.
  - Any req high at the next edge is treated as a new request.
  - No request cancellation.
- Starvation bound: a continuously requesting port waits at most 1 cycle under contention.
- data outputs hold the last captured value until that port's next rdy.
- Reset mid-operation: the in-flight read is discarded, no rdy is issued, and the arbiter returns to idle. Data registers are zeroed.
- Width rules: addresses pass through unmodified (no shifting or alignment); data is captured at full DATA_BITS.
- rom_sel=0 cycles: the ROM returns 0. rom_dout is never captured in those cycles.

Test Plan:
- Single I read: i_req=1, i_addr=0x10 at edge 1, dropped after ack. Expect:
  - i_ack in cycle 2, rom_addr=0x10, rom_sel=1.
  - i_rdy in cycle 3, i_data=mem[0x10].
  - d_* stay 0.
- Simultaneous first conflict: i_req=d_req=1 (0x4 / 0x8) from reset. Expect:
  - I accepted first, D next cycle.
  - i_rdy cycle 3 with mem[0x4]; d_rdy cycle 4 with mem[0x8].
- Sustained contention: both req held high, addresses incrementing per ack for 8 cycles. Expect:
  - acks strictly alternate I, D, I, D….
  - rom_sel continuously 1; 8 rdy pulses, each matching its address.
- Back-to-back single port: I streams 0x0, 0x1, 0x2, 0x3 on consecutive acks. Expect i_rdy high 4 consecutive cycles with mem[0..3] in order, and no bubble.
- Reset mid-flight: assert rst asynchronously in the ack cycle of a D read at 0x20. Expect:
  - All outputs 0 immediately; no d_rdy afterwards.
  - After release, an I/D conflict grants I first.
- Idle and hold: after one D read of 0x30, no reqs for 5 cycles. Expect rom_sel=0, d_data holds mem[0x30], and no spurious ack/rdy.
